// File: rtl/writeback_arbiter.sv
// writeback_arbiter: shares the register-file write port between the in-order
// pipeline writeback and a buffered long-latency result stream. A starvation
// counter forces a one-cycle pipeline stall to drain the buffer. A 32-bit
// scoreboard tracks registers with long-latency results still outstanding.
// Optional feature: define WB_ARB_BYPASS_EN to let a long-latency result skip
// the FIFO when the port is otherwise idle and the FIFO is empty.
module writeback_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pipe_valid,
    input  logic [4:0]  pipe_rd,
    input  logic [31:0] pipe_data,
    output logic        pipe_stall,
    input  logic        ll_valid,
    output logic        ll_ready,
    input  logic [4:0]  ll_rd,
    input  logic [31:0] ll_data,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [31:0] busy_mask
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
    localparam logic [CW-1:0] LIMIT_CNT = CW'(STARVE_LIMIT);

    typedef enum logic {NORMAL, FORCE} state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    state_t        state_q, state_d;
    logic [CW-1:0] starve_q, starve_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          rf_we_q, rf_we_d;
    logic [4:0]    rf_waddr_q, rf_waddr_d;
    logic [31:0]   rf_wdata_q, rf_wdata_d;
    logic [31:0]   busy_q, busy_d;
    entry_t        fifo_q [DEPTH];

    logic   empty, full;
    logic   push, pop, bypass, grant, buf_grant;
    entry_t head, win;

    assign empty      = (count_q == '0);
    assign full       = (count_q == FULL_CNT);
    assign ll_ready   = !full;
    assign head       = fifo_q[rd_ptr_q];
    assign pipe_stall = (state_q == FORCE);
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign busy_mask  = busy_q;

    // Arbitration, FIFO bookkeeping, scoreboard and next write-port values.
    always_comb begin
        state_d    = state_q;
        starve_d   = starve_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        busy_d     = busy_q;
        rf_we_d    = 1'b0;
        rf_waddr_d = rf_waddr_q;
        rf_wdata_d = rf_wdata_q;
        pop        = 1'b0;
        bypass     = 1'b0;
        grant      = 1'b0;
        buf_grant  = 1'b0;
        win        = '0;

        case (state_q)
            FORCE: begin
                // Pipeline is stalled; the buffer owns the port this cycle.
                if (!empty) begin
                    pop       = 1'b1;
                    grant     = 1'b1;
                    buf_grant = 1'b1;
                    win       = head;
                end
                starve_d = '0;
                state_d  = NORMAL;
            end
            default: begin
                if (pipe_valid) begin
                    grant = 1'b1;
                    win   = '{rd: pipe_rd, data: pipe_data};
                    if (!empty) begin
                        starve_d = starve_q + 1'b1;
                        if (starve_d == LIMIT_CNT) state_d = FORCE;
                    end else begin
                        starve_d = '0;
                    end
                end else if (!empty) begin
                    pop       = 1'b1;
                    grant     = 1'b1;
                    buf_grant = 1'b1;
                    win       = head;
                    starve_d  = '0;
                end else begin
                    starve_d = '0;
`ifdef WB_ARB_BYPASS_EN
                    // Idle port and empty FIFO: write the result straight through.
                    if (ll_valid) begin
                        bypass    = 1'b1;
                        grant     = 1'b1;
                        buf_grant = 1'b1;
                        win       = '{rd: ll_rd, data: ll_data};
                    end
`endif
                end
            end
        endcase

        // Push decision uses pre-pop occupancy: a full FIFO never accepts.
        push = ll_valid && !full && !bypass;

        if (push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (!push && pop) count_d = count_q - 1'b1;

        // Clear first so a same-cycle issue to the same register wins.
        if (buf_grant) busy_d[win.rd] = 1'b0;
        if (issue_valid && (issue_rd != 5'd0)) busy_d[issue_rd] = 1'b1;

        // x0 grants still consume their slot but never write.
        if (grant) begin
            rf_we_d    = (win.rd != 5'd0);
            rf_waddr_d = win.rd;
            rf_wdata_d = win.data;
        end
    end

    // Control state, pointers, scoreboard and registered write port.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= NORMAL;
            starve_q   <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            busy_q     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            busy_q     <= busy_d;
            rf_we_q    <= rf_we_d;
            rf_waddr_q <= rf_waddr_d;
            rf_wdata_q <= rf_wdata_d;
        end
    end

    // FIFO storage; contents are only meaningful under the valid count.
    always_ff @(posedge clk) begin
        if (push) fifo_q[wr_ptr_q] <= '{rd: ll_rd, data: ll_data};
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed scenarios followed by
// random traffic, compared each cycle against a queue-based reference model.
module tb_writeback_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pipe_valid = 1'b0;
    logic [4:0]  pipe_rd = '0;
    logic [31:0] pipe_data = '0;
    logic        pipe_stall;
    logic        ll_valid = 1'b0;
    logic        ll_ready;
    logic [4:0]  ll_rd = '0;
    logic [31:0] ll_data = '0;
    logic        issue_valid = 1'b0;
    logic [4:0]  issue_rd = '0;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;

    writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_valid(pipe_valid), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .pipe_stall(pipe_stall),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_rd(ll_rd), .ll_data(ll_data),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .busy_mask(busy_mask)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } res_t;

    // Reference model: buffered results in arrival order, count of
    // consecutive arbitrations the buffer has lost, and a drain-owed flag.
    res_t        q[$];
    int          lost = 0;
    bit          forcing = 1'b0;
    logic [31:0] m_busy = '0;
    logic        m_we = 1'b0;
    logic [4:0]  m_waddr = '0;
    logic [31:0] m_wdata = '0;

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        res_t w;
        bit   g, bufw, bypassed, room;
        w = '0; g = 0; bufw = 0; bypassed = 0;
        if (!rst_n) begin
            q.delete(); lost = 0; forcing = 0;
            m_busy = '0; m_we = 0; m_waddr = '0; m_wdata = '0;
            return;
        end
        room = (q.size() < DEPTH);
        if (forcing) begin
            forcing = 0; lost = 0;
            if (q.size() > 0) begin w = q.pop_front(); g = 1; bufw = 1; end
        end else if (pipe_valid) begin
            w = {pipe_rd, pipe_data}; g = 1;
            if (q.size() > 0) begin
                lost++;
                if (lost == LIMIT) forcing = 1;
            end else lost = 0;
        end else if (q.size() > 0) begin
            w = q.pop_front(); g = 1; bufw = 1; lost = 0;
        end else begin
            lost = 0;
`ifdef WB_ARB_BYPASS_EN
            if (ll_valid) begin w = {ll_rd, ll_data}; g = 1; bufw = 1; bypassed = 1; end
`endif
        end
        if (ll_valid && room && !bypassed) q.push_back({ll_rd, ll_data});
        if (bufw) m_busy[w.rd] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
        m_we = g && (w.rd != 5'd0);
        if (g) begin m_waddr = w.rd; m_wdata = w.data; end
    endtask

    task automatic step();
        bit rdy;
        @(posedge clk);
        model_edge();
        #1;
        rdy = (q.size() < DEPTH);
        check("m_rf_we",    32'(rf_we),      32'(m_we));
        check("m_rf_waddr", 32'(rf_waddr),   32'(m_waddr));
        check("m_rf_wdata", rf_wdata,        m_wdata);
        check("m_busy",     busy_mask,       m_busy);
        check("m_ll_ready", 32'(ll_ready),   32'(rdy));
        check("m_stall",    32'(pipe_stall), 32'(forcing));
    endtask

    task automatic idle();
        pipe_valid = 0; ll_valid = 0; issue_valid = 0;
    endtask

    initial begin
        // Reset with arbitrary inputs.
        pipe_valid = 1; pipe_rd = 5'd9; pipe_data = $urandom;
        ll_valid = 1; ll_rd = 5'd4; ll_data = $urandom;
        issue_valid = 1; issue_rd = 5'd11;
        repeat (3) step();
        check("rst_we",    32'(rf_we), 0);
        check("rst_waddr", 32'(rf_waddr), 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_busy",  busy_mask, 0);
        check("rst_stall", 32'(pipe_stall), 0);
        check("rst_ready", 32'(ll_ready), 1);
        idle(); rst_n = 1;
        step();

        // Pipeline write, then an x0 write.
        pipe_valid = 1; pipe_rd = 5'd5; pipe_data = 32'h1234_5678;
        step();
        check("pipe_we",    32'(rf_we), 1);
        check("pipe_waddr", 32'(rf_waddr), 5);
        check("pipe_wdata", rf_wdata, 32'h1234_5678);
        pipe_rd = 5'd0;
        step();
        check("pipe_x0_we", 32'(rf_we), 0);
        idle();

        // Scoreboard set, then clear on the buffered write.
        issue_valid = 1; issue_rd = 5'd7;
        step();
        issue_valid = 0;
        check("sb_set", 32'(busy_mask[7]), 1);
        ll_valid = 1; ll_rd = 5'd7; ll_data = 32'hDEAD_BEEF;
        step();
        ll_valid = 0;
`ifndef WB_ARB_BYPASS_EN
        check("ll_n1_we",   32'(rf_we), 0);
        check("ll_n1_busy", 32'(busy_mask[7]), 1);
        step();
`endif
        check("ll_we",    32'(rf_we), 1);
        check("ll_waddr", 32'(rf_waddr), 7);
        check("ll_wdata", rf_wdata, 32'hDEAD_BEEF);
        check("ll_clear", 32'(busy_mask[7]), 0);

        // Re-issue in the grant cycle keeps the bit set.
        issue_valid = 1; issue_rd = 5'd7;
        step();
        issue_valid = 0;
        ll_valid = 1; ll_rd = 5'd7; ll_data = 32'h0BAD_F00D;
`ifdef WB_ARB_BYPASS_EN
        issue_valid = 1;
`else
        step();
        ll_valid = 0;
        issue_valid = 1;
`endif
        step();
        idle();
        check("sb_set_wins_we", 32'(rf_we), 1);
        check("sb_set_wins",    32'(busy_mask[7]), 1);
        repeat (2) step();

        // Starvation: buffer non-empty from k=1, stall only at k=5.
        pipe_valid = 1; pipe_rd = 5'd1; pipe_data = 32'd0;
        ll_valid = 1; ll_rd = 5'd12; ll_data = 32'hCAFE_0012;
        for (int k = 1; k <= 7; k++) begin
            step();
            ll_valid = 0;
            check("starve_stall", 32'(pipe_stall), 32'(k == 5));
            if (k == 6) begin
                check("starve_buf_we",    32'(rf_we), 1);
                check("starve_buf_waddr", 32'(rf_waddr), 12);
                check("starve_buf_wdata", rf_wdata, 32'hCAFE_0012);
            end
            if (k == 7) begin
                check("starve_resume_we",    32'(rf_we), 1);
                check("starve_resume_waddr", 32'(rf_waddr), 22);
            end
            pipe_rd = 5'(16 + k); pipe_data = 32'(k);
        end
        idle();
        repeat (3) step();

        // Backpressure: third result waits for a pop.
        pipe_valid = 1; pipe_rd = 5'd2; pipe_data = 32'h55;
        ll_valid = 1; ll_rd = 5'd20; ll_data = 32'hA0;
        check("bp_ready0", 32'(ll_ready), 1);
        step();
        ll_rd = 5'd21; ll_data = 32'hA1;
        check("bp_ready1", 32'(ll_ready), 1);
        step();
        ll_rd = 5'd22; ll_data = 32'hA2;
        check("bp_full", 32'(ll_ready), 0);
        for (int t = 0; t < 20 && !ll_ready; t++) step();
        check("bp_reopen", 32'(ll_ready), 1);
        step();
        ll_valid = 0;
        repeat (10) step();
        pipe_valid = 0;
        repeat (4) step();
        check("bp_drained", 32'(q.size()), 0);

        // Reset mid-operation.
        pipe_valid = 1; ll_valid = 1; ll_rd = 5'd3; ll_data = 32'h33;
        issue_valid = 1; issue_rd = 5'd3;
        step();
        ll_rd = 5'd9; ll_data = 32'h99; issue_rd = 5'd9;
        step();
        idle(); pipe_valid = 1;
        check("mid_busy_set", busy_mask & 32'h0000_0208, 32'h0000_0208);
        check("mid_full", 32'(ll_ready), 0);
        rst_n = 0; pipe_valid = 0;
        step();
        rst_n = 1;
        check("mid_busy", busy_mask, 0);
        check("mid_we", 32'(rf_we), 0);
        check("mid_ready", 32'(ll_ready), 1);
        check("mid_stall", 32'(pipe_stall), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("mid_no_spurious", 32'(rf_we), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            pipe_valid  = ($urandom_range(9) < 7);
            pipe_rd     = 5'($urandom);
            pipe_data   = $urandom;
            ll_valid    = $urandom_range(1);
            ll_rd       = 5'($urandom);
            ll_data     = $urandom;
            issue_valid = ($urandom_range(9) < 3);
            issue_rd    = 5'($urandom);
            rst_n       = ($urandom_range(499) != 0);
            step();
        end
        rst_n = 1; idle();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Shares the single register-file write port between the in-order pipeline writeback value (`pre_wb`, stage-3 result) and a long-latency unit (loads, mul/div) that returns results out of band. Long-latency results are buffered in a small FIFO and drained into idle write-port slots. A starvation counter forces a buffer drain by stalling the pipeline for one cycle. A 32-bit pending-register scoreboard tracks long-latency destinations for hazard detection.

## Interface
- `DEPTH`, default 2: long-latency result FIFO entries, power of two, ≥2.
- `STARVE_LIMIT`, default 4: consecutive lost arbitrations before a forced drain, ≥1.

Clock and reset (already decided): one clock; reset is synchronous and active-low.
- `clk` input 1: clock; all state updates on rising edge.
- `rst_n` input 1: synchronous active-low reset.

Pipeline writeback:
- `pipe_valid` input 1: pipeline writeback present this cycle.
- `pipe_rd` input 5: pipeline destination register.
- `pipe_data` input 32: pipeline writeback value.
- `pipe_stall` output 1: pipeline must hold its writeback and deassert its `clk_enable` this cycle.

Long-latency unit:
- `ll_valid` input 1: long-latency result offered.
- `ll_ready` output 1: FIFO can accept a result.
- `ll_rd` input 5: long-latency destination register.
- `ll_data` input 32: long-latency result value.
- `issue_valid` input 1: long-latency op issued this cycle.
- `issue_rd` input 5: destination of the issued op.

Register file and hazard:
- `rf_we` output 1: register-file write enable (registered).
- `rf_waddr` output 5: write address (registered).
- `rf_wdata` output 32: write data (registered).
- `busy_mask` output 32: bit i set means register i has a long-latency result pending (registered).

## Operation
- **FIFO:**
  - `ll_ready = !full`, from current occupancy only.
  - Push on `ll_valid && ll_ready`.
  - No push when full, even if a pop happens the same cycle.
  - A push into an empty FIFO is poppable no earlier than the next cycle (except under bypass).
- **FSM states:** NORMAL, FORCE. `pipe_stall = (state == FORCE)`, Moore.
- **NORMAL arbitration:**
  - `pipe_valid=1` → pipeline granted.
  - If the FIFO is also non-empty, `starve_cnt++`.
  - When `starve_cnt` reaches `STARVE_LIMIT` → next state FORCE.
  - `pipe_valid=0` and FIFO non-empty → pop head, grant the buffer, `starve_cnt=0`.
  - FIFO empty → `starve_cnt=0`.
- **FORCE:**
  - Pop head and grant the buffer.
  - `pipe_valid` is ignored; the pipeline re-presents its write next cycle.
  - `starve_cnt=0`; next state NORMAL.
- **Grant:** registers `rf_we=1`, `rf_waddr`, and `rf_wdata` from the winner at the next edge. No grant → `rf_we=0`, and address/data hold their previous values.
- **x0 writes:** a grant to rd=0 still completes (FIFO pops) but `rf_we=0`.
- **Scoreboard:**
  - `issue_valid` with `issue_rd≠0` sets the bit.
  - A buffer grant clears the bit for its rd.
  - Set and clear of the same register in the same cycle → set wins.
  - Pipeline writes never touch the scoreboard.
  - Issue to an already-busy register is permitted; the bit stays set.
- **Reset:**
  - Outputs: `rf_we=0`, `rf_waddr=0`, `rf_wdata=0`, `busy_mask=0`, `pipe_stall=0`, `ll_ready=1`.
  - State: FIFO emptied, `starve_cnt=0`, state NORMAL.
  - Reset mid-operation discards buffered results and pending bits.

## Timing
- Pipeline: `pipe_valid` at cycle N → `rf_we` at N+1.
- Long-latency result, no bypass: accepted at N → earliest grant N+1 → `rf_we` at N+2.
- The `busy_mask` bit clears at the same edge that `rf_we` for that result rises.
- Forced drain: FIFO non-empty and `pipe_valid` high for `STARVE_LIMIT` consecutive cycles starting at N:
  - FORCE at N+`STARVE_LIMIT`, with `pipe_stall=1` for exactly that one cycle.
  - Buffer write at N+`STARVE_LIMIT`+1.
- Throughput: one write per cycle. Sustained long-latency pushes every cycle with `pipe_valid=1` fill the FIFO and then backpressure via `ll_ready`.

## Configuration
- **`WB_ARB_BYPASS_EN` defined:** when the FIFO is empty, state is NORMAL, `pipe_valid=0`, and `ll_valid=1`:
  - The result is granted directly without being pushed.
  - `rf_we` at N+1.
  - The scoreboard bit clears at that edge.
- **Not defined:** every long-latency result passes through the FIFO (minimum latency 2).

## Test plan
- **Reset:** hold `rst_n=0` with arbitrary inputs → all outputs at reset values; `ll_ready=1`.
- **Pipeline write:** `pipe_valid=1`, rd=5, data=0x1234_5678 at N → `rf_we=1`, `rf_waddr=5`, `rf_wdata=0x1234_5678` at N+1. Same stimulus with rd=0 → `rf_we=0`.
- **Scoreboard:**
  - Issue rd=7 → `busy_mask[7]=1`.
  - Long-latency result rd=7, data=0xDEAD_BEEF at N with the pipeline idle → write at N+2 (N+1 with bypass); `busy_mask[7]=0` at the same edge.
  - Issue rd=7 in the grant cycle → bit stays 1.
- **Starvation (`STARVE_LIMIT=4`):** `pipe_valid` held high, one long-latency result buffered at N → `pipe_stall=1` only at N+4; buffered write at N+5; pipeline writes resume at N+6.
- **Backpressure (`DEPTH=2`):** three back-to-back long-latency results with `pipe_valid` high → `ll_ready=0` after two pushes; third accepted only after a pop; no data lost or reordered.
- **Reset mid-operation:** FIFO holds two entries and busy bits 3 and 9 are set; pulse `rst_n=0` for one cycle → FIFO empty, `busy_mask=0`, no spurious `rf_we`.
